uart_tx_arbiter: RTL and testbench

- Shares one UART byte transmitter between N_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready byte interface. The arbiter picks one winner, latches its byte, and launches the transmitter with a single-cycle send pulse. The transmitter starts on the rising edge of send.
- The arbiter then tracks transmitter busy until the frame completes. A watchdog catches a transmitter that never acknowledges a launch.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART byte transmitter
// between N_REQ valid/ready requesters, launches frames with a one-cycle send
// strobe, follows the transmitter busy flag and flags launches that are never
// acknowledged.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 done,
    output logic                 err_timeout
);

    localparam int CW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic [7:0]    valid_ext;
    logic [2:0]    win;
    logic          found;
    logic [7:0]    win_data;
    logic          accept;
    logic          timeout_hit;

    // Widen the request vector to 8 bits so it can be indexed by a 3-bit id.
    assign valid_ext   = 8'(req_valid);
    assign accept      = (state == IDLE) && found && !tx_busy;
    assign timeout_hit = (wait_cnt == CW'(BUSY_TIMEOUT - 1));

    // Round-robin search starting one past the last grant, wrapping at N_REQ.
    always_comb begin
        win   = grant_id;
        found = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            if (!found && valid_ext[3'((int'(grant_id) + off) % N_REQ)]) begin
                found = 1'b1;
                win   = 3'((int'(grant_id) + off) % N_REQ);
            end
        end
    end

    // Select the winning requester's byte.
    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == 3'(i)) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    // Next-state and strobe outputs; req_ready is held low while reset is asserted.
    always_comb begin
        state_next = state;
        tx_send    = 1'b0;
        done       = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LAUNCH;
                    for (int i = 0; i < N_REQ; i++) begin
                        req_ready[i] = (win == 3'(i)) && !rst;
                    end
                end
            end
            LAUNCH: begin
                tx_send    = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: latched byte, grant index, activity, watchdog and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data     <= 8'h00;
            grant_id    <= 3'(N_REQ - 1);
            active      <= 1'b0;
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data  <= win_data;
                        grant_id <= win;
                        active   <= 1'b1;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                end
                WAIT_BUSY: begin
                    if (!tx_busy) begin
                        if (timeout_hit) begin
                            err_timeout <= 1'b1;
                            active      <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        active <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench with a behavioural transmitter and a
// round-robin reference model for uart_tx_arbiter.
module tb_uart_tx_arbiter;

    localparam int N_REQ        = 4;
    localparam int BUSY_TIMEOUT = 4;
    localparam int FRAME        = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_ready;
    logic                 tx_send;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [2:0]           grant_id;
    logic                 active;
    logic                 done;
    logic                 err_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_delay = 1;
    int unstable = 0;
    int model_last = N_REQ - 1;
    logic [7:0] sent_q[$];
    logic [7:0] frame_byte;

    uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_send(tx_send), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
        .done(done), .err_timeout(err_timeout)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure grant spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural transmitter: busy rises tx_delay cycles after the send pulse
    // and stays high for FRAME cycles; tx_delay of 0 models a dead transmitter.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1 && tx_delay > 0) begin
                frame_byte = tx_data;
                sent_q.push_back(tx_data);
                repeat (tx_delay) @(posedge clk);
                #1 tx_busy = 1'b1;
                for (int b = 0; b < FRAME; b++) begin
                    @(negedge clk);
                    if (tx_data !== frame_byte) unstable++;
                    @(posedge clk);
                    #1;
                end
                tx_busy = 1'b0;
            end
        end
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] time limit");
    end

    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((active !== 1'b0 || tx_busy !== 1'b0) && guard < 200);
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: active=%b tx_busy=%b want both 0", active, tx_busy);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, tx_send, active, done, err_timeout} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000000", {req_ready, tx_send, active, done, err_timeout});
        end
        checks++;
        if (grant_id !== 3'(N_REQ - 1)) begin
            errors++;
            $display("FAIL reset_grant_id: got %0d want %0d", grant_id, N_REQ - 1);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_data: got %h want 00", tx_data);
        end
        step();
        rst = 1'b0;
        step();
        model_last = N_REQ - 1;
    endtask

    task automatic test_single();
        logic seen;
        seen = 1'b0;
        sent_q.delete();
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({tx_send, active, grant_id, tx_data} !== {1'b1, 1'b1, 3'd0, 8'hA5}) begin
            errors++;
            $display("FAIL single_launch: send=%b active=%b grant=%0d data=%h want 1 1 0 a5", tx_send, active, grant_id, tx_data);
        end
        for (int j = 0; j < 60 && !seen; j++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL single_done: got no done pulse want one");
        end
        checks++;
        if ({tx_data, grant_id, err_timeout} !== {8'hA5, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_at_done: data=%h grant=%0d err=%b want a5 0 0", tx_data, grant_id, err_timeout);
        end
        step();
        checks++;
        if (sent_q.size() != 1 || sent_q[0] !== 8'hA5 || unstable != 0) begin
            errors++;
            $display("FAIL single_sent: count=%0d unstable=%0d want 1 byte a5 stable", sent_q.size(), unstable);
        end
        model_last = 0;
        wait_idle();
    endtask

    task automatic test_all_four();
        int order[5] = '{0, 1, 2, 3, 0};
        logic [7:0] bytes[4] = '{8'h10, 8'h21, 8'h32, 8'h43};
        int tstamp[5];
        int g, guard;
        logic [N_REQ-1:0] exp_ready;
        wait_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sent_q.delete();
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111;
        g = 0;
        guard = 0;
        while (g < 5 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (req_ready !== 4'b0000) begin
                exp_ready = '0;
                exp_ready[order[g]] = 1'b1;
                checks++;
                if (req_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL all_order[%0d]: got %b want %b", g, req_ready, exp_ready);
                end
                tstamp[g] = cyc;
                if (g > 0) begin
                    checks++;
                    if (tstamp[g] - tstamp[g-1] != FRAME + 3) begin
                        errors++;
                        $display("FAIL all_spacing[%0d]: got %0d want %0d", g, tstamp[g] - tstamp[g-1], FRAME + 3);
                    end
                end
                g++;
            end
        end
        checks++;
        if (g < 5) begin
            errors++;
            $display("FAIL all_grants: got %0d grants want 5", g);
        end
        step();
        req_valid = '0;
        model_last = 0;
        wait_idle();
        checks++;
        if (sent_q.size() != 5) begin
            errors++;
            $display("FAIL all_sent_count: got %0d want 5", sent_q.size());
        end
        for (int k = 0; k < 5 && k < sent_q.size(); k++) begin
            checks++;
            if (sent_q[k] !== bytes[order[k]]) begin
                errors++;
                $display("FAIL all_byte[%0d]: got %h want %h", k, sent_q[k], bytes[order[k]]);
            end
        end
    endtask

    task automatic test_fairness();
        int grants, since2, count2, guard, e;
        logic [N_REQ-1:0] exp_ready;
        wait_idle();
        req_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        grants = 0;
        since2 = 0;
        count2 = 0;
        guard = 0;
        while (grants < 12 && guard < 600) begin
            req_valid = {1'($urandom), 1'b1, 1'b0, 1'($urandom)};
            @(negedge clk);
            guard++;
            if (req_ready !== 4'b0000) begin
                e = rr_pick(req_valid, model_last);
                exp_ready = '0;
                if (e >= 0) exp_ready[e] = 1'b1;
                checks++;
                if (req_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL fair_pick[%0d]: got %b want %b", grants, req_ready, exp_ready);
                end
                if (e == 2) begin
                    since2 = 0;
                    count2++;
                end else begin
                    since2++;
                end
                checks++;
                if (since2 > N_REQ - 1) begin
                    errors++;
                    $display("FAIL fair_starve: got %0d grants without req2 want at most %0d", since2, N_REQ - 1);
                end
                if (e >= 0) model_last = e;
                grants++;
            end
            step();
        end
        req_valid = '0;
        checks++;
        if (count2 < 2 || grants < 12) begin
            errors++;
            $display("FAIL fair_total: got grants=%0d req2=%0d want 12 and >=2", grants, count2);
        end
        wait_idle();
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] drop;
        logic [N_REQ-1:0] exp_ready;
        logic [7:0] exp_q[$];
        int e, c;
        wait_idle();
        sent_q.delete();
        unstable = 0;
        drop = '0;
        req_valid = '0;
        c = 0;
        while ((c < 300 || req_valid != 0) && c < 1500) begin
            if (c < 300) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (!req_valid[i] && $urandom_range(3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end
            end
            @(negedge clk);
            if (req_ready !== 4'b0000) begin
                e = rr_pick(req_valid, model_last);
                exp_ready = '0;
                if (e >= 0) exp_ready[e] = 1'b1;
                checks++;
                if (req_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL rand_pick: got %b want %b valid %b", req_ready, exp_ready, req_valid);
                end
                if (e >= 0) begin
                    exp_q.push_back(req_data[8*e +: 8]);
                    model_last = e;
                end
                drop = req_ready;
            end
            step();
            req_valid = req_valid & ~drop;
            drop = '0;
            c++;
        end
        req_valid = '0;
        wait_idle();
        checks++;
        if (sent_q.size() != exp_q.size() || unstable != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d bytes unstable=%0d want %0d bytes unstable=0", sent_q.size(), unstable, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < sent_q.size(); k++) begin
            checks++;
            if (sent_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rand_byte[%0d]: got %h want %h", k, sent_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_busy_last();
        logic seen;
        seen = 1'b0;
        wait_idle();
        tx_delay = BUSY_TIMEOUT;
        req_data[15:8] = 8'hC3;
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL busylast_ready: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (tx_send !== 1'b1) begin
            errors++;
            $display("FAIL busylast_send: got %b want 1", tx_send);
        end
        repeat (BUSY_TIMEOUT + 1) @(negedge clk);
        checks++;
        if ({err_timeout, active} !== 2'b01) begin
            errors++;
            $display("FAIL busylast_state: err=%b active=%b want 0 1", err_timeout, active);
        end
        for (int j = 0; j < 60 && !seen; j++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL busylast_done: done_seen=%b err=%b want 1 0", seen, err_timeout);
        end
        model_last = 1;
        step();
        tx_delay = 1;
        wait_idle();
    endtask

    task automatic test_timeout();
        logic seen;
        seen = 1'b0;
        wait_idle();
        sent_q.delete();
        tx_delay = 0;
        req_data[23:16] = 8'h5A;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_ready: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (tx_send !== 1'b1) begin
            errors++;
            $display("FAIL timeout_send: got %b want 1", tx_send);
        end
        for (int j = 1; j <= BUSY_TIMEOUT; j++) begin
            @(negedge clk);
            checks++;
            if ({err_timeout, done} !== 2'b00) begin
                errors++;
                $display("FAIL timeout_early[%0d]: err=%b done=%b want 0 0", j, err_timeout, done);
            end
        end
        @(negedge clk);
        checks++;
        if ({err_timeout, active, done} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_flag: err=%b active=%b done=%b want 1 0 0", err_timeout, active, done);
        end
        model_last = 2;
        step();
        tx_delay = 1;
        req_data[31:24] = 8'h77;
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_regrant: got %b want 1000", req_ready);
        end
        step();
        req_valid = '0;
        for (int j = 0; j < 60 && !seen; j++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || err_timeout !== 1'b1 || sent_q.size() != 1 || sent_q[0] !== 8'h77) begin
            errors++;
            $display("FAIL timeout_after: done_seen=%b err=%b sent=%0d want 1 1 1 byte 77", seen, err_timeout, sent_q.size());
        end
        model_last = 3;
        step();
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        wait_idle();
        req_data[7:0] = 8'h3C;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++;
        if ({tx_send, active, req_ready, done, err_timeout} !== 8'h00) begin
            errors++;
            $display("FAIL midrst_flags: got %b want 00000000", {tx_send, active, req_ready, done, err_timeout});
        end
        checks++;
        if (grant_id !== 3'(N_REQ - 1) || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_regs: grant=%0d data=%h want %0d 00", grant_id, tx_data, N_REQ - 1);
        end
        repeat (FRAME + 2) step();
        rst = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (req_ready === 4'b0000 && guard < 100);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_first_grant: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        wait_idle();
    endtask

    // Test sequence and summary.
    initial begin
        $display("[TB] start");
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_random();
        test_busy_last();
        test_timeout();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
